sobel_stream_filter: RTL and testbench
======================================

# sobel_stream_filter

Parametrised streaming 3x3 Sobel edge filter: the next-generation core behind edge_detection_top. It accepts a raster-order pixel stream of any frame size and pixel width, and emits exactly one output pixel per input pixel, with zeroed borders. It self-flushes the last row at end of frame, using a ready handshake to hold off input during the flush.

## Interface
- IMAGE_WIDTH, 128, pixels per row (>= 4)
- IMAGE_HEIGHT, 128, rows per frame (>= 3)
- PIXEL_W, 8, bits per pixel in and out
- THRESHOLD, 128, binarisation level (used only with SOBEL_THRESHOLD_EN)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- image_data  in  PIXEL_W  input pixel, raster order
- data_valid  in  1  image_data valid
- data_ready  out  1  block can accept; a transfer occurs when data_valid && data_ready
- edge_output  out  PIXEL_W  filtered pixel
- edge_valid  out  1  edge_output valid, one cycle per pixel
- frame_done  out  1  one-cycle pulse coinciding with the last output pixel of a frame

## Operation
- Input counters col (0..IMAGE_WIDTH-1) and row (0..IMAGE_HEIGHT-1) advance on each transfer and wrap at end of frame.
- Two line buffers (depth IMAGE_WIDTH) plus shift registers form the 3x3 window.
- Output pixel k (k = row*IMAGE_WIDTH + col) is triggered by the transfer of input k+IMAGE_WIDTH+1, or by a flush step.
- Gx = [-1 0 1; -2 0 2; -1 0 1]. Gy = [-1 -2 -1; 0 0 0; 1 2 1].
- Magnitude = |Gx| + |Gy|, computed at PIXEL_W+4 bits, saturated to 2^PIXEL_W - 1.
- Border outputs (row 0, row IMAGE_HEIGHT-1, col 0, col IMAGE_WIDTH-1) are forced to 0. Window data never wraps across rows or frames.
- FSM states:
  - FILL: first IMAGE_WIDTH+1 transfers of a frame; no outputs triggered. Go to RUN after transfer IMAGE_WIDTH+1.
  - RUN: each transfer triggers one output. Go to FLUSH on the transfer of the last frame pixel.
  - FLUSH: data_ready = 0. Exactly IMAGE_WIDTH+1 internal steps, one per cycle, each triggering one output using zero-padded virtual pixels. Then go to FILL.
- Every frame produces exactly IMAGE_WIDTH*IMAGE_HEIGHT outputs in raster order.
- data_valid gaps in FILL/RUN stall the pipeline trigger only; no output is lost or duplicated.
- data_valid while data_ready = 0 is ignored.

## Timing
- Reset values: edge_output = 0, edge_valid = 0, frame_done = 0, data_ready = 1, state FILL, counters 0. Line buffer contents are don't-care (masked by FILL).
- Latency: edge_valid asserts exactly 2 cycles after its triggering transfer or flush step (window register, then arithmetic/output register).
- data_ready is registered:
  - low from the cycle after the last-pixel transfer, for exactly IMAGE_WIDTH+1 cycles;
  - high again in the cycle after the final flush step.
- Back-to-back frames: a transfer in the first cycle data_ready returns high is the new frame's pixel 0.
- frame_done asserts with edge_valid of output IMAGE_WIDTH*IMAGE_HEIGHT-1, i.e. 2 cycles after the last flush step.
- Reset asserted mid-frame or mid-flush: all outputs return to reset values immediately. In-flight pixels are discarded, and the next transfer after release is pixel 0.

## Configuration
- SOBEL_THRESHOLD_EN defined: edge_output = all-ones if saturated magnitude >= THRESHOLD, else 0. Borders are still 0.
- Not defined: edge_output = saturated magnitude. THRESHOLD is ignored.
- Latency is identical in both builds.

## Structure
- sobel_pkg holds:
  - state enum (FILL, RUN, FLUSH);
  - kernel coefficient constants;
  - magnitude width constant (PIXEL_W+4) and saturation helper.
- One sub-module, sobel_line_buffer: a single-port-per-cycle circular RAM of depth IMAGE_WIDTH and width PIXEL_W, with a write-enable-gated pointer. It is instantiated twice.

## Test plan
- 8x8 frame, all pixels 0x40, continuous data_valid -> 64 outputs all 0x00; frame_done on output 63; data_ready low for exactly 9 cycles after pixel 63.
- 8x8 vertical step (cols 0-3 = 0x00, cols 4-7 = 0xFF), magnitude build -> rows 1-6 give 0xFF at cols 3 and 4 (1020 saturated), 0x00 elsewhere; rows 0 and 7 all 0x00.
- Same step stream with data_valid toggling 1-0-1 randomly -> output sequence bit-identical to the continuous case; no extra edge_valid cycles.
- SOBEL_THRESHOLD_EN, THRESHOLD = 128, 8x8 horizontal ramp of 0x10 per column -> interior |Gx| = 128 -> interior outputs 0xFF, borders 0x00.
- Two frames back-to-back, 8x8, second frame is the step image -> first frame 64 outputs, second frame 64 correct outputs; pixel 0 is accepted in the first data_ready-high cycle.
- reset pulsed low at input pixel 30 of an 8x8 frame -> edge_valid, frame_done, edge_output immediately 0 and data_ready 1. The fresh flat frame after release yields 64 zero outputs and a single frame_done.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel filter.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sobel_state_t;

    // Kernels indexed [row][col], row 0 = oldest line, col 0 = leftmost pixel.
    localparam int GX_K [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int GY_K [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    // Guard bits above the pixel width for the gradient arithmetic.
    localparam int MAG_GUARD = 4;

    function automatic int mag_width(input int pixel_w);
        return pixel_w + MAG_GUARD;
    endfunction

    // True when a magnitude no longer fits in a pixel of the given width.
    function automatic logic needs_saturation(input logic [31:0] mag, input int pixel_w);
        return mag > ((32'd1 << pixel_w) - 32'd1);
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Circular line store: reading the current slot returns the pixel written
// DEPTH writes earlier, and the same slot is overwritten on wr_en.
module sobel_line_buffer #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    assign rd_data = mem[ptr];

    // Pointer moves only on a write so the delay is always exactly DEPTH steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (wr_en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

    // Storage carries no reset; stale contents are masked by the fill phase.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= wr_data;
        end
    end
endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter with zeroed borders and end-of-frame self-flush.
// Optional build macro SOBEL_THRESHOLD_EN: binarise the magnitude against THRESHOLD.
//
// state | meaning
// FILL  | first IMAGE_WIDTH+1 pixels of a frame, window not yet centred on pixel 0
// RUN   | every accepted pixel triggers one output
// FLUSH | input held off, IMAGE_WIDTH+1 zero-padded steps drain the last outputs
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128,
    parameter int PIXEL_W      = 8,
    parameter int THRESHOLD    = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W-1:0] image_data,
    input  logic               data_valid,
    output logic               data_ready,
    output logic [PIXEL_W-1:0] edge_output,
    output logic               edge_valid,
    output logic               frame_done
);
    localparam int CW    = $clog2(IMAGE_WIDTH);
    localparam int RW    = $clog2(IMAGE_HEIGHT);
    localparam int FW    = $clog2(IMAGE_WIDTH + 1);
    localparam int MAG_W = mag_width(PIXEL_W);

    sobel_state_t state, next_state;

    logic [CW-1:0]      col, out_col;
    logic [RW-1:0]      row, out_row;
    logic [FW-1:0]      flush_cnt;
    logic               transfer, step, trigger, ready_next, last_in;
    logic [PIXEL_W-1:0] step_pix, lb1_out, lb2_out, sat, pix_val;
    logic [PIXEL_W-1:0] win [3][3];
    logic               valid1, border1, last1;
    logic signed [MAG_W-1:0] gx, gy, ax, ay, mag;

    assign transfer = data_valid && data_ready;
    assign last_in  = (row == RW'(IMAGE_HEIGHT - 1)) && (col == CW'(IMAGE_WIDTH - 1));
    assign step_pix = (state == FLUSH) ? '0 : image_data;

    // State and registered ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FILL;
            data_ready <= 1'b1;
        end else begin
            state      <= next_state;
            data_ready <= ready_next;
        end
    end

    // Next state, window step and output trigger.
    always_comb begin
        next_state = state;
        step       = 1'b0;
        trigger    = 1'b0;
        unique case (state)
            FILL: begin
                step = transfer;
                if (transfer && row == RW'(1) && col == '0) next_state = RUN;
            end
            RUN: begin
                step    = transfer;
                trigger = transfer;
                if (transfer && last_in) next_state = FLUSH;
            end
            FLUSH: begin
                step    = 1'b1;
                trigger = 1'b1;
                if (flush_cnt == '0) next_state = FILL;
            end
            default: next_state = FILL;
        endcase
        ready_next = (next_state != FLUSH);
    end

    // Flush step down-counter, preloaded outside FLUSH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
        end else if (state != FLUSH) begin
            flush_cnt <= FW'(IMAGE_WIDTH);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FW'(1);
        end
    end

    // Raster position of the next accepted input pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (transfer) begin
            if (col == CW'(IMAGE_WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(IMAGE_HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_W)) u_lb1 (
        .clk(clk), .reset(reset), .wr_en(step), .wr_data(step_pix), .rd_data(lb1_out)
    );

    sobel_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(PIXEL_W)) u_lb2 (
        .clk(clk), .reset(reset), .wr_en(step), .wr_data(lb1_out), .rd_data(lb2_out)
    );

    // 3x3 window shifts left one column per step; contents need no reset.
    always_ff @(posedge clk) begin
        if (step) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_out;
            win[1][2] <= lb1_out;
            win[2][2] <= step_pix;
        end
    end

    // Output-pixel position tracking; border and end-of-frame flags travel with the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_col <= '0;
            out_row <= '0;
            valid1  <= 1'b0;
            border1 <= 1'b0;
            last1   <= 1'b0;
        end else begin
            valid1 <= trigger;
            if (trigger) begin
                border1 <= (out_row == '0) || (out_row == RW'(IMAGE_HEIGHT - 1)) ||
                           (out_col == '0) || (out_col == CW'(IMAGE_WIDTH - 1));
                last1   <= (out_row == RW'(IMAGE_HEIGHT - 1)) && (out_col == CW'(IMAGE_WIDTH - 1));
                if (out_col == CW'(IMAGE_WIDTH - 1)) begin
                    out_col <= '0;
                    out_row <= (out_row == RW'(IMAGE_HEIGHT - 1)) ? '0 : out_row + RW'(1);
                end else begin
                    out_col <= out_col + CW'(1);
                end
            end
        end
    end

    // Gradient magnitude, saturation and optional binarisation.
    always_comb begin
        gx = '0;
        gy = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                gx = gx + MAG_W'(GX_K[r][c] * int'(win[r][c]));
                gy = gy + MAG_W'(GY_K[r][c] * int'(win[r][c]));
            end
        end
        ax  = gx[MAG_W-1] ? -gx : gx;
        ay  = gy[MAG_W-1] ? -gy : gy;
        mag = ax + ay;
        sat = needs_saturation(32'(mag), PIXEL_W) ? '1 : mag[PIXEL_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
        pix_val = (32'(sat) >= 32'(THRESHOLD)) ? '1 : '0;
`else
        pix_val = sat;
`endif
    end

    // Output register with border masking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_output <= '0;
            edge_valid  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            edge_valid <= valid1;
            frame_done <= valid1 && last1;
            if (valid1) begin
                edge_output <= border1 ? '0 : pix_val;
            end
        end
    end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Self-checking bench for sobel_stream_filter on an 8x8 frame.
// Honours SOBEL_THRESHOLD_EN in its reference model.
module tb_sobel_stream_filter;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int THR = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] image_data = '0;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic [7:0] edge_output;
    logic       edge_valid;
    logic       frame_done;

    sobel_stream_filter #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_W(8), .THRESHOLD(THR)
    ) dut (
        .clk(clk), .reset(reset), .image_data(image_data), .data_valid(data_valid),
        .data_ready(data_ready), .edge_output(edge_output), .edge_valid(edge_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        bit last;
        int t;
    } exp_t;

    exp_t exp_q[$];
    int   img [H][W];
    int   tests = 0;
    int   fails = 0;
    int   low_run = 0;
    int   first_t = 0;
    int   last_t = 0;

    task automatic check(input string name, input int got, input int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: full-frame Sobel on the bench's own copy of the image.
    function automatic int model_pix(input int r, input int c);
        int gx, gy, mag;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
        mag = iabs(gx) + iabs(gy);
        if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= THR) ? 255 : 0;
`else
        return mag;
`endif
    endfunction

    task automatic set_image(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0: img[r][c] = 'h40;
                    1: img[r][c] = (c >= 4) ? 'hFF : 'h00;
                    default: img[r][c] = c * 'h10;
                endcase
    endtask

    task automatic push_exp(input int k, input int t, input bit last);
        exp_t e;
        e.val  = model_pix(k / W, k % W);
        e.last = last;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send_pixel(input int p, output int t);
        int guard;
        guard = 0;
        data_valid = 1'b1;
        image_data = 8'(p);
        while (!data_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: data_ready stayed 0 for %0d cycles", guard);
        end
        t = cyc;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic send_frame(input bit gaps, input int npix);
        int t;
        for (int n = 0; n < npix; n++) begin
            if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
            send_pixel(img[n / W][n % W], t);
            if (n == 0) first_t = t;
            last_t = t;
            if (n >= W + 1) push_exp(n - W - 1, t + 2, 1'b0);
            if (n == W * H - 1)
                for (int j = 0; j <= W; j++)
                    push_exp(W * H - W - 1 + j, t + 3 + j, j == W);
        end
    endtask

    task automatic drain;
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Compare process: every output cycle against the model queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                low_run = 0;
            end else begin
                if (!data_ready) begin
                    low_run++;
                end else if (low_run != 0) begin
                    check("ready_low_cycles", low_run, W + 1);
                    low_run = 0;
                end
                if (edge_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL extra_output: value %0d with nothing expected", edge_output);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_value", edge_output, e.val);
                        check("frame_done", frame_done, e.last);
                        check("latency_cycle", cyc, e.t);
                    end
                end else if (frame_done) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_frame_done: got 1 expected 0 without edge_valid");
                end
            end
        end
    end

    initial begin
        int t_prev;
        repeat (3) @(negedge clk);
        check("rst_edge_output", edge_output, 0);
        check("rst_edge_valid", edge_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_data_ready", data_ready, 1);
        reset = 1'b1;
        @(negedge clk);

        set_image(1);
        check("model_step_c3", model_pix(3, 3), 255);
        check("model_step_c4", model_pix(3, 4), 255);
        check("model_step_c2", model_pix(3, 2), 0);
        check("model_step_row0", model_pix(0, 3), 0);
        set_image(2);
`ifdef SOBEL_THRESHOLD_EN
        check("model_ramp", model_pix(4, 4), 255);
`else
        check("model_ramp", model_pix(4, 4), 128);
`endif
        set_image(0);
        check("model_flat", model_pix(4, 4), 0);

        set_image(0);
        send_frame(1'b0, W * H);
        drain();

        set_image(1);
        send_frame(1'b0, W * H);
        drain();

        set_image(1);
        send_frame(1'b1, W * H);
        drain();

        set_image(2);
        send_frame(1'b0, W * H);
        drain();

        set_image(0);
        send_frame(1'b0, W * H);
        t_prev = last_t;
        set_image(1);
        send_frame(1'b0, W * H);
        check("b2b_pixel0_cycle", first_t, t_prev + W + 2);
        drain();

        set_image(1);
        send_frame(1'b0, 30);
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_edge_output", edge_output, 0);
        check("midrst_edge_valid", edge_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_data_ready", data_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        set_image(0);
        send_frame(1'b0, W * H);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
